// File: rtl/spdif_frame_scheduler.sv
// spdif_frame_scheduler: sequences left/right audio samples into 32-bit
// S/PDIF subframes with preamble select, channel-status and validity bits.
// Optional build macro: SPDIF_PARITY_EN (adds the even-parity bit P).
module spdif_frame_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_left_data,
  input  logic             i_left_valid,
  output logic             o_left_ready,
  input  logic [WIDTH-1:0] i_right_data,
  input  logic             i_right_valid,
  output logic             o_right_ready,
  input  logic [31:0]      i_cstat_word,
  output logic [31:0]      o_tx_word,
  output logic [1:0]       o_tx_preamble,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic [7:0]       o_frame_count,
  output logic             o_underrun
);

  typedef enum logic [2:0] {IDLE, LOAD_L, SEND_L, LOAD_R, SEND_R} state_t;

  localparam logic [7:0] LAST_FRAME = 8'd191;
  localparam logic [1:0] PRE_B = 2'd0, PRE_M = 2'd1, PRE_W = 2'd2;

  state_t      r_state, w_next;
  logic [7:0]  r_frame_count;
  logic [31:0] r_tx_word;
  logic [1:0]  r_tx_preamble;

  logic             w_left_ready, w_right_ready, w_tx_valid, w_underrun;
  logic             w_is_left, w_load, w_sel_valid;
  logic [WIDTH-1:0] w_sel_data;
  logic [23:0]      w_samp24;
  logic             w_c, w_p;
  logic [30:0]      w_body;
  logic [1:0]       w_pre;

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state and handshake outputs; enable only matters at frame boundaries.
  always_comb begin
    w_next        = r_state;
    w_left_ready  = 1'b0;
    w_right_ready = 1'b0;
    w_tx_valid    = 1'b0;
    w_underrun    = 1'b0;
    case (r_state)
      IDLE:   if (i_enable) w_next = LOAD_L;
      LOAD_L: begin
        w_left_ready = i_left_valid;
        w_underrun   = ~i_left_valid;
        w_next       = SEND_L;
      end
      SEND_L: begin
        w_tx_valid = 1'b1;
        if (i_tx_ready) w_next = LOAD_R;
      end
      LOAD_R: begin
        w_right_ready = i_right_valid;
        w_underrun    = ~i_right_valid;
        w_next        = SEND_R;
      end
      SEND_R: begin
        w_tx_valid = 1'b1;
        if (i_tx_ready) w_next = i_enable ? LOAD_L : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Subframe assembly from whichever channel is being loaded; a missing
  // sample becomes zero audio with V set.
  always_comb begin
    w_is_left   = (r_state == LOAD_L);
    w_load      = (r_state == LOAD_L) || (r_state == LOAD_R);
    w_sel_valid = w_is_left ? i_left_valid : i_right_valid;
    w_sel_data  = w_is_left ? i_left_data  : i_right_data;
    w_samp24    = w_sel_valid ? (24'(w_sel_data) << (24 - WIDTH)) : 24'd0;
    w_c         = (r_frame_count < 8'd32) ? i_cstat_word[r_frame_count[4:0]] : 1'b0;
    w_body      = {w_c, 1'b0, ~w_sel_valid, w_samp24, 4'b0000};
`ifdef SPDIF_PARITY_EN
    w_p         = ^w_body[30:4];
`else
    w_p         = 1'b0;
`endif
    w_pre       = w_is_left ? ((r_frame_count == 8'd0) ? PRE_B : PRE_M) : PRE_W;
  end

  // Subframe holding register: written only in LOAD_x, so it stays stable
  // for the whole SEND_x stall.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tx_word     <= 32'd0;
      r_tx_preamble <= 2'd0;
    end else if (w_load) begin
      r_tx_word     <= {w_p, w_body};
      r_tx_preamble <= w_pre;
    end
  end

  // Frame index advances once the right subframe is accepted.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_frame_count <= 8'd0;
    else if (r_state == SEND_R && i_tx_ready)
      r_frame_count <= (r_frame_count == LAST_FRAME) ? 8'd0 : r_frame_count + 8'd1;
  end

  assign o_left_ready  = w_left_ready;
  assign o_right_ready = w_right_ready;
  assign o_tx_valid    = w_tx_valid;
  assign o_underrun    = w_underrun;
  assign o_tx_word     = r_tx_word;
  assign o_tx_preamble = r_tx_preamble;
  assign o_frame_count = r_frame_count;

endmodule
